uart_rx_core: RTL and testbench

- Synthesizable UART receiver on the SoC side of the serial link; the host-side UART transmitter drives its RX pin.
- Oversamples the line at 16x baud, frames 8N1 characters LSB-first and checks the stop bit.
- Buffers received bytes in a small FIFO and presents them to the bus-side UART register logic over a valid/ready interface.

---
 rtl/uart_rx_core.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, stop-bit check, small receive FIFO
// presented to the bus side through a valid/ready pop interface.
module uart_rx_core #(
  parameter int CLK_DIV    = 8,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic                 r_sync1;
  logic                 r_rx_s;
  logic [TW-1:0]        r_tcnt;
  logic                 w_tick;
  state_t               r_state;
  logic [3:0]           r_scnt;
  logic [BW-1:0]        r_bidx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 w_stop_sample;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overrun;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr;

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_rx_s  <= r_sync1;
    end
  end

  // Free-running: the phase is never realigned to the start edge.
  always_ff @(posedge Clk) begin
    if (rst || w_tick) r_tcnt <= '0;
    else               r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_tick = (r_tcnt == TW'(CLK_DIV - 1));

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_scnt      <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_rx_s) begin
              r_scnt  <= '0;
              r_state <= ST_START;
            end
          end
          ST_START: begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd7) begin
              if (!r_rx_s) begin
                r_scnt  <= '0;
                r_bidx  <= '0;
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            // scnt wraps 15->0, so consecutive samples are 16 ticks apart
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd15) begin
              r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bidx == BW'(DATA_BITS - 1)) r_state <= ST_STOP;
              else                              r_bidx  <= r_bidx + 1'b1;
            end
          end
          ST_STOP: begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd15) begin
              if (r_rx_s) begin
                r_state <= ST_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (r_rx_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_stop_sample = (r_state == ST_STOP) && w_tick && (r_scnt == 4'd15);
  assign w_push        = w_stop_sample && r_rx_s;
  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_pop         = rx_valid && rx_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_wr          = w_push && (!w_full || w_pop);

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data   = r_mem[r_rptr];
  assign rx_valid  = (r_count != '0);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives 8N1 frames at 128 clocks/bit and scores the
// popped bytes, error pulses and timing against expectations built here.
// Handshake: a byte transfers on every cycle where rx_valid && rx_ready.
module tb_uart_rx_core;

  localparam int BIT = 128;
  localparam int HALF_TICKS_9_5 = 1216;

  logic       Clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx_core #(.CLK_DIV(8), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .rst(rst), .RX(RX), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int last_lat  = 0;
  int n_fe = 0, n_ov = 0, n_vcyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge Clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge Clk) begin
    if (!rst) begin
      if (frame_err) n_fe++;
      if (overrun)   n_ov++;
      if (rx_valid)  n_vcyc++;
      if (rx_valid && !prev_valid) last_lat = cyc - start_cyc;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check_eq("pop_with_expectation", 32'(exp_q.size()), 32'd1);
        else check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = rx_valid;
  end

  // driver: start bit, 8 data bits LSB first, stop bit of the given level
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (BIT) @(negedge Clk);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, v0;
    logic [9:0] f;

    repeat (5) @(negedge Clk);
    rst = 1'b0;
    check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);

    // idle line
    idle(2000);
    check_eq("idle_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_frame_err_cnt", n_fe, 0);
    check_eq("idle_overrun_cnt", n_ov, 0);

    // back-to-back 0x55, 0xA3; window is 9.5 bits +/-1 tick plus 3 cycles of sync/register latency
    v0 = n_vcyc;
    exp_q.push_back(8'h55);
    last_lat = 0;
    send_frame(8'h55, 1'b1);
    check_eq("lat_55_in_window", 32'(last_lat >= HALF_TICKS_9_5 - 8 && last_lat <= HALF_TICKS_9_5 + 8 + 3), 32'd1);
    exp_q.push_back(8'hA3);
    last_lat = 0;
    send_frame(8'hA3, 1'b1);
    check_eq("lat_A3_in_window", 32'(last_lat >= HALF_TICKS_9_5 - 8 && last_lat <= HALF_TICKS_9_5 + 8 + 3), 32'd1);
    idle(64);
    check_eq("valid_cycles_two_bytes", n_vcyc - v0, 2);
    check_eq("q_empty_after_pair", 32'(exp_q.size()), 32'd0);

    // framing error, then recovery
    fe0 = n_fe; v0 = n_vcyc;
    send_frame(8'h3C, 1'b0);
    idle(256);
    check_eq("frame_err_pulses", n_fe - fe0, 1);
    check_eq("no_push_on_ferr", n_vcyc - v0, 0);
    check_eq("idle_after_break", {29'd0, dbg_state}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(64);
    check_eq("q_empty_after_81", 32'(exp_q.size()), 32'd0);

    // short glitch
    fe0 = n_fe; v0 = n_vcyc;
    RX = 1'b0;
    repeat (60) @(negedge Clk);
    idle(300);
    check_eq("glitch_busy", {31'd0, busy}, 32'd0);
    check_eq("glitch_no_push", n_vcyc - v0, 0);
    check_eq("glitch_no_ferr", n_fe - fe0, 0);

    // overrun: five bytes into a four-entry FIFO with no consumer
    rx_ready = 1'b0;
    ov0 = n_ov;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    idle(32);
    check_eq("overrun_pulses", n_ov - ov0, 1);
    check_eq("full_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("head_stable", {24'd0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    idle(10);
    check_eq("drained_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("q_empty_after_drain", 32'(exp_q.size()), 32'd0);

    // reset mid-frame with two bytes buffered
    rx_ready = 1'b0;
    fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_eq("buffered_before_rst", {31'd0, rx_valid}, 32'd1);
    f = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 4; i++) begin
      RX = f[i];
      repeat (BIT) @(negedge Clk);
    end
    RX = f[4];
    repeat (BIT / 2) @(negedge Clk);
    check_eq("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0;
    RX = 1'b1;
    check_eq("post_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    rx_ready = 1'b1;
    idle(20 * BIT);
    check_eq("post_rst_no_ferr", n_fe - fe0, 0);
    check_eq("post_rst_no_overrun", n_ov - ov0, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(64);
    check_eq("q_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
